// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   PC_W             : program-counter width
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden
//   PC_INC           : sequential PC increment (one 32-bit instruction)
//   fetch_state_e    : fetch FSM state encoding
//   is_misaligned    : true when a PC is not word aligned
package fetch_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [PC_W-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_npc_sel.sv
// Next-PC priority mux for the fetch stage.
// Priority: jr, then jal, then taken branch, then sequential.
// Optional build macro: PC_ALIGN_CHECK_EN -- when defined, align_fault_o
// flags a selected npc whose low two bits are non-zero; otherwise it is 0.
// Ports:
//   jr_op_i / jr_target_i          : jr/jalr in D and its forwarded target
//   jal_op_i / jump_target_i       : jal/j in D and its target
//   branch_taken_i / branch_target_i : taken branch in D and its target
//   seq_pc_i                       : sequential PC (pcF + 4)
//   npc_o                          : selected next PC
//   align_fault_o                  : selected npc is not word aligned
module npc_sel
  import fetch_pkg::*;
(
  input  logic            jr_op_i,
  input  logic [PC_W-1:0] jr_target_i,
  input  logic            jal_op_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic [PC_W-1:0] seq_pc_i,
  output logic [PC_W-1:0] npc_o,
  output logic            align_fault_o
);

  always_comb begin
    if (jr_op_i) begin
      npc_o = jr_target_i;
    end else if (jal_op_i) begin
      npc_o = jump_target_i;
    end else if (branch_taken_i) begin
      npc_o = branch_target_i;
    end else begin
      npc_o = seq_pc_i;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  assign align_fault_o = is_misaligned(npc_o);
`else
  assign align_fault_o = 1'b0;
`endif

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, requests instructions from memory
// with a request/ready handshake, picks the next PC and reacts to stalls.
// Optional build macro: PC_ALIGN_CHECK_EN (misaligned next-PC -> ERR).
//
// Handshake: imemReq is high in every FETCH cycle with imemAddr = pcF.
// An instruction is accepted in the cycle where imemReq && imemReady &&
// !stallF; that cycle raises fetchDoneF combinationally and the PC
// advances at the following edge. imemReady is ignored whenever imemReq
// is low.
//
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-low reset
//   stallF            : hazard freeze of F/D
//   pcSrcD/pcBranchD  : taken branch and target
//   jalOp/pcJumpD     : jal/j and target
//   jrOp/rd1D         : jr/jalr and forwarded rs target
//   imemReq/imemAddr  : instruction-memory request and address
//   imemReady         : memory data valid this cycle
//   fetchDoneF        : instruction accepted this cycle
//   pcF/pcPlus4F      : current fetch PC and pcF + 4
//   fetchErr          : sticky timeout / alignment error
//   stallCnt          : saturating count of non-advancing cycles
//   dbgState          : current FSM state (fetch_state_e encoding)
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              TIMEOUT  = 16,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallF,
  input  logic             pcSrcD,
  input  logic [PC_W-1:0]  pcBranchD,
  input  logic             jalOp,
  input  logic [PC_W-1:0]  pcJumpD,
  input  logic             jrOp,
  input  logic [PC_W-1:0]  rd1D,
  output logic             imemReq,
  output logic [PC_W-1:0]  imemAddr,
  input  logic             imemReady,
  output logic             fetchDoneF,
  output logic [PC_W-1:0]  pcF,
  output logic [PC_W-1:0]  pcPlus4F,
  output logic             fetchErr,
  output logic [CNT_W-1:0] stallCnt,
  output logic [1:0]       dbgState
);

  // One spare bit so TIMEOUT values that are powers of two still fit.
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [PC_W-1:0]  npc;
  logic             align_fault;
  logic             in_fetch;
  logic             advance;
  logic             no_progress;

  npc_sel u_npc_sel (
    .jr_op_i         (jrOp),
    .jr_target_i     (rd1D),
    .jal_op_i        (jalOp),
    .jump_target_i   (pcJumpD),
    .branch_taken_i  (pcSrcD),
    .branch_target_i (pcBranchD),
    .seq_pc_i        (pcPlus4F),
    .npc_o           (npc),
    .align_fault_o   (align_fault)
  );

  assign in_fetch    = (state_q == FETCH);
  assign advance     = in_fetch && imemReady && !stallF;
  assign no_progress = (in_fetch && !advance) || (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    err_d   = err_q;
    stall_d = stall_q;

    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (advance) begin
          wait_d = '0;
          // The completing instruction is still delivered; only the bad
          // target is refused.
          if (align_fault) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            pc_d = npc;
          end
        end else if (imemReady) begin
          // Data arrived while frozen: drop it and refetch after HOLD.
          state_d = HOLD;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      HOLD: begin
        if (!stallF) state_d = FETCH;
      end
      ERR: state_d = ERR;
      default: state_d = BOOT;
    endcase

    if (no_progress && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign imemReq    = in_fetch;
  assign imemAddr   = pc_q;
  assign fetchDoneF = advance;
  assign pcF        = pc_q;
  assign pcPlus4F   = pc_q + PC_INC;
  assign fetchErr   = err_q;
  assign stallCnt   = stall_q;
  assign dbgState   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             stallF = 1'b0;
  logic             pcSrcD = 1'b0;
  logic [31:0]      pcBranchD = '0;
  logic             jalOp = 1'b0;
  logic [31:0]      pcJumpD = '0;
  logic             jrOp = 1'b0;
  logic [31:0]      rd1D = '0;
  logic             imemReq;
  logic [31:0]      imemAddr;
  logic             imemReady = 1'b0;
  logic             fetchDoneF;
  logic [31:0]      pcF;
  logic [31:0]      pcPlus4F;
  logic             fetchErr;
  logic [CNT_W-1:0] stallCnt;
  logic [1:0]       dbgState;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  fetch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stallF(stallF),
    .pcSrcD(pcSrcD), .pcBranchD(pcBranchD),
    .jalOp(jalOp), .pcJumpD(pcJumpD),
    .jrOp(jrOp), .rd1D(rd1D),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady),
    .fetchDoneF(fetchDoneF), .pcF(pcF), .pcPlus4F(pcPlus4F),
    .fetchErr(fetchErr), .stallCnt(stallCnt), .dbgState(dbgState)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // drivers: inputs change on the falling edge, outputs are sampled #1 later
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_redirects();
    pcSrcD = 1'b0; pcBranchD = '0;
    jalOp  = 1'b0; pcJumpD   = '0;
    jrOp   = 1'b0; rd1D      = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0; stallF = 1'b0; imemReady = 1'b0;
    clear_redirects();
    exp_q.delete();
    step(); step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (dbgState !== BOOT) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbgState, BOOT); end
    n_cmp++; if (pcF !== 32'h3000) begin n_err++; $display("FAIL reset_pc: got %h want %h", pcF, 32'h3000); end
    n_cmp++; if (imemReq !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imemReq); end
    n_cmp++; if (fetchDoneF !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", fetchDoneF); end
    n_cmp++; if (fetchErr !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", fetchErr); end
    n_cmp++; if (stallCnt !== '0) begin n_err++; $display("FAIL reset_stallcnt: got %0d want 0", stallCnt); end
  endtask

  // BOOT for one cycle, then one instruction per cycle from 0x3000.
  task automatic test_sequential();
    do_reset();
    imemReady = 1'b1;
    #1;
    n_cmp++; if (imemReq !== 1'b0) begin n_err++; $display("FAIL seq_boot_req: got %b want 0", imemReq); end
    step();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h3000 + 32'(4 * i));
      #1;
      if (fetchDoneF === 1'b1 && exp_q.size() != 0) begin
        exp_pc = exp_q.pop_front();
        n_cmp++; if (pcF !== exp_pc) begin n_err++; $display("FAIL seq_pc: got %h want %h", pcF, exp_pc); end
        n_cmp++; if (imemAddr !== exp_pc) begin n_err++; $display("FAIL seq_addr: got %h want %h", imemAddr, exp_pc); end
        n_cmp++; if (pcPlus4F !== exp_pc + 32'd4) begin n_err++; $display("FAIL seq_plus4: got %h want %h", pcPlus4F, exp_pc + 32'd4); end
      end else begin
        n_cmp++; n_err++; $display("FAIL seq_done: got %b want 1", fetchDoneF);
      end
      n_cmp++; if (stallCnt !== '0) begin n_err++; $display("FAIL seq_stallcnt: got %0d want 0", stallCnt); end
      step();
    end
  endtask

  // Continues at pcF=0x3010: branch, then jr+jal+branch together (jr wins).
  task automatic test_redirect();
    logic [31:0] exp_tab [3];
    exp_tab[0] = 32'h3010; exp_tab[1] = 32'h3100; exp_tab[2] = 32'h3200;
    for (int i = 0; i < 3; i++) begin
      clear_redirects();
      if (i == 0) begin pcSrcD = 1'b1; pcBranchD = 32'h3100; end
      if (i == 1) begin
        jrOp = 1'b1; rd1D = 32'h3200; jalOp = 1'b1; pcJumpD = 32'h3300;
        pcSrcD = 1'b1; pcBranchD = 32'h3400;
      end
      exp_q.push_back(exp_tab[i]);
      #1;
      if (fetchDoneF === 1'b1 && exp_q.size() != 0) begin
        exp_pc = exp_q.pop_front();
        n_cmp++; if (pcF !== exp_pc) begin n_err++; $display("FAIL redir_pc: got %h want %h", pcF, exp_pc); end
      end else begin
        n_cmp++; n_err++; $display("FAIL redir_done: got %b want 1", fetchDoneF);
      end
      step();
    end
    clear_redirects();
    #1;
    n_cmp++; if (pcF !== 32'h3204) begin n_err++; $display("FAIL redir_after: got %h want %h", pcF, 32'h3204); end
  endtask

  // stallF for 3 cycles at 0x3020, redirects asserted meanwhile must be ignored.
  task automatic test_hold();
    do_reset();
    imemReady = 1'b1;
    step();
    for (int i = 0; i < 8; i++) step();
    for (int c = 0; c < 4; c++) begin
      stallF = (c < 3);
      jrOp = 1'b1; rd1D = 32'h5000; pcSrcD = 1'b1; pcBranchD = 32'h6000;
      #1;
      n_cmp++; if (fetchDoneF !== 1'b0) begin n_err++; $display("FAIL hold_done: got %b want 0 (cycle %0d)", fetchDoneF, c); end
      n_cmp++; if (pcF !== 32'h3020) begin n_err++; $display("FAIL hold_pc: got %h want %h", pcF, 32'h3020); end
      if (c > 0) begin
        n_cmp++; if (imemReq !== 1'b0) begin n_err++; $display("FAIL hold_req: got %b want 0", imemReq); end
        n_cmp++; if (dbgState !== HOLD) begin n_err++; $display("FAIL hold_state: got %0d want %0d", dbgState, HOLD); end
      end
      step();
    end
    clear_redirects();
    exp_q.push_back(32'h3020);
    #1;
    if (fetchDoneF === 1'b1 && exp_q.size() != 0) begin
      exp_pc = exp_q.pop_front();
      n_cmp++; if (pcF !== exp_pc) begin n_err++; $display("FAIL hold_refetch: got %h want %h", pcF, exp_pc); end
    end else begin
      n_cmp++; n_err++; $display("FAIL hold_refetch_done: got %b want 1", fetchDoneF);
    end
    step();
    #1;
    n_cmp++; if (pcF !== 32'h3024) begin n_err++; $display("FAIL hold_next: got %h want %h", pcF, 32'h3024); end
    n_cmp++; if (stallCnt !== 6'd4) begin n_err++; $display("FAIL hold_stallcnt: got %0d want 4", stallCnt); end
  endtask

  // 16 un-ready FETCH cycles -> ERR; only reset recovers.
  task automatic test_timeout();
    do_reset();
    imemReady = 1'b0;
    step();
    for (int i = 0; i < 15; i++) step();
    #1;
    n_cmp++; if (fetchErr !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %b want 0", fetchErr); end
    n_cmp++; if (imemReq !== 1'b1) begin n_err++; $display("FAIL tmo_req_early: got %b want 1", imemReq); end
    step();
    #1;
    n_cmp++; if (dbgState !== ERR) begin n_err++; $display("FAIL tmo_state: got %0d want %0d", dbgState, ERR); end
    n_cmp++; if (fetchErr !== 1'b1) begin n_err++; $display("FAIL tmo_err: got %b want 1", fetchErr); end
    n_cmp++; if (imemReq !== 1'b0) begin n_err++; $display("FAIL tmo_req: got %b want 0", imemReq); end
    n_cmp++; if (stallCnt !== 6'd16) begin n_err++; $display("FAIL tmo_stallcnt: got %0d want 16", stallCnt); end
    imemReady = 1'b1;
    #1;
    n_cmp++; if (fetchDoneF !== 1'b0) begin n_err++; $display("FAIL tmo_done: got %b want 0", fetchDoneF); end
    step(); step();
    #1;
    n_cmp++; if (pcF !== 32'h3000) begin n_err++; $display("FAIL tmo_pc_frozen: got %h want %h", pcF, 32'h3000); end
    n_cmp++; if (stallCnt !== 6'd16) begin n_err++; $display("FAIL tmo_err_nocount: got %0d want 16", stallCnt); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    n_cmp++; if (dbgState !== BOOT) begin n_err++; $display("FAIL tmo_rst_state: got %0d want %0d", dbgState, BOOT); end
    n_cmp++; if (fetchErr !== 1'b0) begin n_err++; $display("FAIL tmo_rst_err: got %b want 0", fetchErr); end
    n_cmp++; if (stallCnt !== '0) begin n_err++; $display("FAIL tmo_rst_cnt: got %0d want 0", stallCnt); end
    n_cmp++; if (pcF !== 32'h3000) begin n_err++; $display("FAIL tmo_rst_pc: got %h want %h", pcF, 32'h3000); end
  endtask

  // Jump to 0xFFFF_FFFC, then sequential wrap to 0.
  task automatic test_wrap();
    do_reset();
    imemReady = 1'b1;
    step();
    jrOp = 1'b1; rd1D = 32'hFFFF_FFFC;
    step();
    clear_redirects();
    exp_q.push_back(32'hFFFF_FFFC);
    #1;
    if (fetchDoneF === 1'b1 && exp_q.size() != 0) begin
      exp_pc = exp_q.pop_front();
      n_cmp++; if (pcF !== exp_pc) begin n_err++; $display("FAIL wrap_top: got %h want %h", pcF, exp_pc); end
    end else begin
      n_cmp++; n_err++; $display("FAIL wrap_done: got %b want 1", fetchDoneF);
    end
    n_cmp++; if (pcPlus4F !== 32'h0) begin n_err++; $display("FAIL wrap_plus4_top: got %h want 0", pcPlus4F); end
    step();
    #1;
    n_cmp++; if (pcF !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want 0", pcF); end
    n_cmp++; if (pcPlus4F !== 32'h4) begin n_err++; $display("FAIL wrap_plus4: got %h want 4", pcPlus4F); end
  endtask

  // Stall counter saturates at all ones (CNT_W=6 -> 63).
  task automatic test_saturate();
    do_reset();
    imemReady = 1'b1;
    step();
    stallF = 1'b1;
    for (int i = 0; i < 62; i++) step();
    #1;
    n_cmp++; if (stallCnt !== 6'd62) begin n_err++; $display("FAIL sat_below: got %0d want 62", stallCnt); end
    for (int i = 0; i < 8; i++) step();
    #1;
    n_cmp++; if (stallCnt !== 6'd63) begin n_err++; $display("FAIL sat_top: got %0d want 63", stallCnt); end
    stallF = 1'b0;
  endtask

  // Misaligned branch target.
  task automatic test_align();
    do_reset();
    imemReady = 1'b1;
    step();
    pcSrcD = 1'b1; pcBranchD = 32'h3102;
    #1;
    n_cmp++; if (fetchDoneF !== 1'b1) begin n_err++; $display("FAIL align_done: got %b want 1", fetchDoneF); end
    step();
    clear_redirects();
    imemReady = 1'b0;
    #1;
`ifdef PC_ALIGN_CHECK_EN
    n_cmp++; if (dbgState !== ERR) begin n_err++; $display("FAIL align_state: got %0d want %0d", dbgState, ERR); end
    n_cmp++; if (fetchErr !== 1'b1) begin n_err++; $display("FAIL align_err: got %b want 1", fetchErr); end
    n_cmp++; if (pcF !== 32'h3000) begin n_err++; $display("FAIL align_pc: got %h want %h", pcF, 32'h3000); end
`else
    n_cmp++; if (pcF !== 32'h3102) begin n_err++; $display("FAIL align_pc: got %h want %h", pcF, 32'h3102); end
    n_cmp++; if (imemAddr !== 32'h3102) begin n_err++; $display("FAIL align_addr: got %h want %h", imemAddr, 32'h3102); end
    n_cmp++; if (fetchErr !== 1'b0) begin n_err++; $display("FAIL align_err: got %b want 0", fetchErr); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_hold();
    test_timeout();
    test_wrap();
    test_saturate();
    test_align();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
